uart_frame_scheduler: RTL and testbench

// Shares the single uart_transmit instance between two frame sources:
// src0 = pre-emphasised audio window, src1 = reordered FFT magnitudes.

---
 rtl/uart_frame_scheduler.sv | 152 +++++++++++++++
 tb/tb_uart_frame_scheduler.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_scheduler.sv
// Round-robin arbiter and byte sequencer that shares one UART transmitter between two frame sources.
// Frame: SYNC x SYNC_LEN, ID, LEN_HI, LEN_LO, payload, CHECKSUM; payload fetched through a fixed-latency read port.
module uart_frame_scheduler #(
    parameter logic [7:0]  SYNC_BYTE  = 8'hFF,
    parameter int unsigned SYNC_LEN   = 4,
    parameter int unsigned LEN_W      = 9,
    parameter int unsigned MAX_LEN    = 420,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [1:0]       req_in,
    input  logic [LEN_W-1:0] len0_in,
    input  logic [LEN_W-1:0] len1_in,
    output logic [1:0]       grant_out,
    output logic [1:0]       done_out,
    output logic             rd_en_out,
    output logic [LEN_W-1:0] rd_addr_out,
    input  logic [7:0]       rd_data_in,
    output logic [7:0]       tx_byte_out,
    output logic             tx_trigger_out,
    input  logic             tx_busy_in,
    output logic             busy_out
);

    localparam int unsigned HDR_N  = SYNC_LEN + 3;
    localparam int unsigned HCNT_W = 4;
    localparam int unsigned WAIT_W = $clog2(RD_LATENCY + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_GRANT, S_HDR, S_FETCH, S_RDWAIT, S_SEND, S_TXWAIT, S_CSUM, S_DONE
    } state_t;

    state_t              state, next_state;
    logic                src, rr_last, trig_d;
    logic [LEN_W-1:0]    len_q, idx;
    logic [HCNT_W-1:0]   hdr_cnt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [7:0]          data_q, sum_q;
    logic                tx_ready_c, pick_c, fire_c, rd_last_c;
    logic [LEN_W-1:0]    len_raw_c, len_clamp_c;
    logic [15:0]         len16_c;
    logic [7:0]          hdr_byte_c, byte_c;

    // The trigger cycle and the one after it are blind: busy may not have risen yet.
    assign tx_ready_c  = !tx_busy_in && !tx_trigger_out && !trig_d;
    assign pick_c      = (req_in == 2'b11) ? ~rr_last : req_in[1];
    assign len_raw_c   = src ? len1_in : len0_in;
    assign len_clamp_c = (len_raw_c > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len_raw_c;
    assign len16_c     = 16'(len_q);
    assign rd_last_c   = (wait_cnt == WAIT_W'(RD_LATENCY - 1));

    always_comb begin : hdr_mux
        hdr_byte_c = len16_c[7:0];
        if (hdr_cnt < HCNT_W'(SYNC_LEN))
            hdr_byte_c = SYNC_BYTE;
        else if (hdr_cnt == HCNT_W'(SYNC_LEN))
            hdr_byte_c = {7'b0, src};
        else if (hdr_cnt == HCNT_W'(SYNC_LEN + 1))
            hdr_byte_c = len16_c[15:8];
    end

    always_ff @(posedge clk_in) begin : state_reg
        if (rst_in) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin : next_state_logic
        next_state = state;
        case (state)
            S_IDLE:   if (|req_in) next_state = S_GRANT;
            S_GRANT:  next_state = S_HDR;
            S_HDR:    if (tx_ready_c && hdr_cnt == HCNT_W'(HDR_N - 1)) next_state = S_TXWAIT;
            S_TXWAIT: if (tx_ready_c) next_state = (idx < len_q) ? S_FETCH : S_CSUM;
            S_FETCH:  next_state = S_RDWAIT;
            S_RDWAIT: if (rd_last_c) next_state = S_SEND;
            S_SEND:   if (tx_ready_c) next_state = S_TXWAIT;
            S_CSUM:   if (tx_ready_c) next_state = S_DONE;
            S_DONE:   next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // Which byte (if any) goes to the transmitter this cycle.
    always_comb begin : output_logic
        fire_c = 1'b0;
        byte_c = tx_byte_out;
        case (state)
            S_GRANT: begin fire_c = tx_ready_c; byte_c = SYNC_BYTE;  end
            S_HDR:   begin fire_c = tx_ready_c; byte_c = hdr_byte_c; end
            S_SEND:  begin fire_c = tx_ready_c; byte_c = data_q;     end
            S_CSUM:  begin fire_c = tx_ready_c; byte_c = sum_q;      end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in) begin : datapath
        if (rst_in) begin
            grant_out      <= '0;
            done_out       <= '0;
            rd_en_out      <= 1'b0;
            rd_addr_out    <= '0;
            tx_byte_out    <= '0;
            tx_trigger_out <= 1'b0;
            busy_out       <= 1'b0;
            src            <= 1'b0;
            rr_last        <= 1'b1;
            trig_d         <= 1'b0;
            len_q          <= '0;
            idx            <= '0;
            hdr_cnt        <= '0;
            wait_cnt       <= '0;
            data_q         <= '0;
            sum_q          <= '0;
        end else begin
            trig_d         <= tx_trigger_out;
            tx_trigger_out <= fire_c;
            if (fire_c) tx_byte_out <= byte_c;
            busy_out  <= (next_state != S_IDLE);
            done_out  <= (next_state == S_DONE) ? {src, ~src} : 2'b00;
            rd_en_out <= (next_state == S_FETCH);
            if (next_state == S_FETCH) rd_addr_out <= idx;
            if (next_state == S_IDLE)
                grant_out <= 2'b00;
            else if (state == S_IDLE)
                grant_out <= {pick_c, ~pick_c};
            if (state == S_IDLE && |req_in) begin
                src     <= pick_c;
                rr_last <= pick_c;
                hdr_cnt <= '0;
                idx     <= '0;
            end
            if (state == S_GRANT) begin
                len_q <= len_clamp_c;
                sum_q <= '0;
            end
            if (fire_c && (state == S_GRANT || state == S_HDR))
                hdr_cnt <= hdr_cnt + HCNT_W'(1);
            if (state == S_FETCH)
                wait_cnt <= '0;
            else if (state == S_RDWAIT)
                wait_cnt <= wait_cnt + WAIT_W'(1);
            if (state == S_RDWAIT && rd_last_c)
                data_q <= rd_data_in;
            if (fire_c && state == S_SEND) begin
                sum_q <= sum_q + data_q;
                idx   <= idx + LEN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// Bench for uart_frame_scheduler: UART busy model, 2-cycle read-port model and a frame-level reference model.
module tb_uart_frame_scheduler;

    localparam int MAX_LEN = 420;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic [1:0] req_in = 2'b00;
    logic [8:0] len0_in = '0, len1_in = '0;
    logic [1:0] grant_out, done_out;
    logic       rd_en_out, tx_trigger_out, busy_out;
    logic [8:0] rd_addr_out;
    logic [7:0] rd_data_in = '0, tx_byte_out;
    logic       tx_busy_in = 1'b0;

    always #5 clk_in = ~clk_in;

    uart_frame_scheduler dut (
        .clk_in(clk_in), .rst_in(rst_in), .req_in(req_in),
        .len0_in(len0_in), .len1_in(len1_in),
        .grant_out(grant_out), .done_out(done_out),
        .rd_en_out(rd_en_out), .rd_addr_out(rd_addr_out), .rd_data_in(rd_data_in),
        .tx_byte_out(tx_byte_out), .tx_trigger_out(tx_trigger_out), .tx_busy_in(tx_busy_in),
        .busy_out(busy_out)
    );

    int n_checks = 0, n_fail = 0;
    logic [7:0] mem [0:1][0:511];
    logic [7:0] txq[$], expq[$];
    int doneq[$], grantq[$], rdaddrq[$];
    int trig_cnt, busy_viol, rd_viol, hot_viol, gap_viol;
    int busy_cyc = 5, bcnt = 0, cyc = 0, first_trig_cyc = -1;
    logic [1:0] prev_grant = 2'b00;
    logic       v1 = 1'b0, v2 = 1'b0;
    logic [7:0] d1 = '0, d2 = '0;

    always @(posedge clk_in) cyc++;

    // UART busy model, read-port model and bus monitor, all sampled mid-cycle.
    always @(negedge clk_in) begin
        if (tx_trigger_out) begin
            if (tx_busy_in) busy_viol++;
            if (txq.size() == 0) first_trig_cyc = cyc;
            txq.push_back(tx_byte_out);
            trig_cnt++;
            bcnt = busy_cyc;
        end else if (bcnt > 0) begin
            bcnt--;
        end
        tx_busy_in = (bcnt > 0);
        if (rd_en_out) begin
            rdaddrq.push_back(int'(rd_addr_out));
            if (grant_out == 2'b00) rd_viol++;
        end
        if (done_out != 2'b00) doneq.push_back(int'(done_out[1]));
        if (grant_out != 2'b00 && !$onehot(grant_out)) hot_viol++;
        if (prev_grant != 2'b00 && grant_out != 2'b00 && grant_out != prev_grant) gap_viol++;
        if (prev_grant == 2'b00 && grant_out != 2'b00) grantq.push_back(int'(grant_out[1]));
        prev_grant = grant_out;
        rd_data_in = v2 ? d2 : 8'($urandom);
        v2 = v1;
        d2 = d1;
        v1 = rd_en_out;
        d1 = mem[int'(grant_out[1])][int'(rd_addr_out)];
    end

    task automatic clear_mon();
        txq.delete(); expq.delete(); doneq.delete(); grantq.delete(); rdaddrq.delete();
        trig_cnt = 0; busy_viol = 0; rd_viol = 0; hot_viol = 0; gap_viol = 0;
        first_trig_cyc = -1;
    endtask

    task automatic do_reset();
        req_in = 2'b00;
        rst_in = 1'b1;
        repeat (3) @(posedge clk_in);
        #1 rst_in = 1'b0;
        repeat (20) @(posedge clk_in);
        #1;
    endtask

    // Frame as the scheduler should emit it, computed directly from the packet layout.
    task automatic model_frame(input int src, input int len_req);
        int l, s;
        l = (len_req > MAX_LEN) ? MAX_LEN : len_req;
        s = 0;
        repeat (4) expq.push_back(8'hFF);
        expq.push_back(8'(src));
        expq.push_back(8'(l / 256));
        expq.push_back(8'(l % 256));
        for (int i = 0; i < l; i++) begin
            expq.push_back(mem[src][i]);
            s += int'(mem[src][i]);
        end
        expq.push_back(8'(s % 256));
    endtask

    function automatic int first_diff();
        int n;
        n = (txq.size() < expq.size()) ? txq.size() : expq.size();
        for (int i = 0; i < n; i++)
            if (txq[i] !== expq[i]) return i;
        if (txq.size() != expq.size()) return n;
        return -1;
    endfunction

    task automatic wait_done(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30000; i++) begin
            @(posedge clk_in);
            if (doneq.size() >= n) begin ok = 1'b1; break; end
        end
        #1;
    endtask

    task automatic wait_trig(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30000; i++) begin
            @(posedge clk_in);
            if (trig_cnt >= n) begin ok = 1'b1; break; end
        end
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({grant_out, done_out, rd_en_out, rd_addr_out, tx_byte_out, tx_trigger_out, busy_out} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: grant=%b done=%b rd_en=%b addr=%0d byte=%h trig=%b busy=%b, required all 0",
                     grant_out, done_out, rd_en_out, rd_addr_out, tx_byte_out, tx_trigger_out, busy_out);
        end
    endtask

    task automatic test_basic();
        logic [7:0] exp_b [11] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'h06};
        bit ok;
        int t0, bad;
        clear_mon();
        busy_cyc = 10;
        mem[0][0] = 8'h01; mem[0][1] = 8'h02; mem[0][2] = 8'h03;
        len0_in = 9'd3;
        t0 = cyc;
        req_in = 2'b01;
        wait_done(1, ok);
        req_in = 2'b00;
        repeat (15) @(posedge clk_in);
        #1;
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL basic_timeout: done seen=%0d, required 1", doneq.size()); end
        bad = 0;
        for (int i = 0; i < 11; i++) if (i >= txq.size() || txq[i] !== exp_b[i]) bad++;
        n_checks++;
        if (bad != 0 || txq.size() != 11) begin
            n_fail++; $display("FAIL basic_bytes: %0d wrong of %0d sent, required 11 exact", bad, txq.size());
        end
        n_checks++;
        if (trig_cnt != 11) begin n_fail++; $display("FAIL basic_trig_count: %0d, required 11", trig_cnt); end
        n_checks++;
        if (busy_viol != 0) begin n_fail++; $display("FAIL basic_trig_while_busy: %0d, required 0", busy_viol); end
        n_checks++;
        if (doneq.size() != 1 || doneq[0] != 0) begin
            n_fail++; $display("FAIL basic_done: %0d pulses, required one done_out[0]", doneq.size());
        end
        n_checks++;
        if (first_trig_cyc - t0 != 2) begin
            n_fail++; $display("FAIL basic_first_trig_latency: %0d cycles, required 2", first_trig_cyc - t0);
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        int d;
        do_reset();
        clear_mon();
        busy_cyc = 3;
        mem[0][0] = 8'($urandom);
        mem[1][0] = 8'($urandom);
        len0_in = 9'd1;
        len1_in = 9'd1;
        req_in = 2'b11;
        wait_done(3, ok);
        req_in = 2'b00;
        repeat (15) @(posedge clk_in);
        #1;
        model_frame(0, 1); model_frame(1, 1); model_frame(0, 1);
        n_checks++;
        if (!ok || doneq.size() != 3 || doneq[0] != 0 || doneq[1] != 1 || doneq[2] != 0) begin
            n_fail++; $display("FAIL rr_done_order: %0d pulses, required src0,src1,src0", doneq.size());
        end
        n_checks++;
        if (grantq.size() != 3 || grantq[0] != 0 || grantq[1] != 1 || grantq[2] != 0) begin
            n_fail++; $display("FAIL rr_grant_order: %0d grants, required src0,src1,src0", grantq.size());
        end
        n_checks++;
        if (hot_viol != 0 || gap_viol != 0) begin
            n_fail++; $display("FAIL rr_grant_shape: onehot errs=%0d gapless switches=%0d, required 0/0", hot_viol, gap_viol);
        end
        d = first_diff();
        n_checks++;
        if (d != -1) begin n_fail++; $display("FAIL rr_bytes: first difference at %0d, required none", d); end
    endtask

    task automatic test_zero_len();
        bit ok;
        int d;
        clear_mon();
        busy_cyc = 6;
        len1_in = 9'd0;
        req_in = 2'b10;
        wait_done(1, ok);
        req_in = 2'b00;
        repeat (10) @(posedge clk_in);
        #1;
        model_frame(1, 0);
        d = first_diff();
        n_checks++;
        if (!ok || d != -1) begin n_fail++; $display("FAIL zero_bytes: first difference at %0d (done=%0d), required none", d, ok); end
        n_checks++;
        if (rdaddrq.size() != 0) begin n_fail++; $display("FAIL zero_reads: %0d reads, required 0", rdaddrq.size()); end
        n_checks++;
        if (doneq.size() != 1 || doneq[0] != 1) begin n_fail++; $display("FAIL zero_done: %0d pulses, required one done_out[1]", doneq.size()); end
    endtask

    task automatic test_clamp();
        bit ok;
        int d, bad;
        clear_mon();
        busy_cyc = 1;
        for (int i = 0; i < 512; i++) mem[0][i] = 8'($urandom);
        len0_in = 9'd500;
        req_in = 2'b01;
        wait_done(1, ok);
        req_in = 2'b00;
        repeat (10) @(posedge clk_in);
        #1;
        model_frame(0, 500);
        n_checks++;
        if (rdaddrq.size() != 420) begin n_fail++; $display("FAIL clamp_reads: %0d reads, required 420", rdaddrq.size()); end
        bad = 0;
        for (int i = 0; i < rdaddrq.size(); i++) if (rdaddrq[i] != i) bad++;
        n_checks++;
        if (bad != 0 || rd_viol != 0) begin n_fail++; $display("FAIL clamp_addr: %0d out of order, %0d ungranted, required 0/0", bad, rd_viol); end
        n_checks++;
        if (txq.size() < 7 || txq[5] !== 8'h01 || txq[6] !== 8'hA4) begin
            n_fail++; $display("FAIL clamp_len_bytes: %0d bytes sent, required LEN 01 A4", txq.size());
        end
        d = first_diff();
        n_checks++;
        if (!ok || d != -1) begin n_fail++; $display("FAIL clamp_bytes: first difference at %0d (done=%0d), required none", d, ok); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int d;
        clear_mon();
        busy_cyc = 4;
        for (int i = 0; i < 20; i++) mem[0][i] = 8'($urandom);
        len0_in = 9'd20;
        req_in = 2'b01;
        wait_trig(12, ok);
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        n_checks++;
        if (!ok || {grant_out, done_out, rd_en_out, rd_addr_out, tx_byte_out, tx_trigger_out, busy_out} !== '0) begin
            n_fail++; $display("FAIL midreset_outputs: grant=%b busy=%b trig=%b byte=%h (reached=%0d), required all 0",
                               grant_out, busy_out, tx_trigger_out, tx_byte_out, ok);
        end
        rst_in = 1'b0;
        req_in = 2'b00;
        repeat (20) @(posedge clk_in);
        #1;
        n_checks++;
        if (doneq.size() != 0) begin n_fail++; $display("FAIL midreset_no_done: %0d pulses, required 0", doneq.size()); end
        clear_mon();
        mem[1][0] = 8'($urandom);
        mem[1][1] = 8'($urandom);
        len1_in = 9'd2;
        req_in = 2'b10;
        wait_done(1, ok);
        req_in = 2'b00;
        repeat (10) @(posedge clk_in);
        #1;
        model_frame(1, 2);
        d = first_diff();
        n_checks++;
        if (!ok || d != -1) begin n_fail++; $display("FAIL midreset_fresh_frame: first difference at %0d (done=%0d), required none", d, ok); end
    endtask

    task automatic test_req_drop();
        bit ok1, ok2, ok3;
        int d;
        clear_mon();
        busy_cyc = 2;
        for (int i = 0; i < 6; i++) mem[0][i] = 8'($urandom);
        for (int i = 0; i < 3; i++) mem[1][i] = 8'($urandom);
        len0_in = 9'd6;
        len1_in = 9'd3;
        req_in = 2'b01;
        wait_trig(1, ok1);
        req_in = 2'b00;
        wait_trig(4, ok2);
        req_in = 2'b10;
        wait_done(2, ok3);
        req_in = 2'b00;
        repeat (10) @(posedge clk_in);
        #1;
        model_frame(0, 6);
        model_frame(1, 3);
        n_checks++;
        if (!(ok1 && ok2 && ok3) || doneq.size() != 2 || doneq[0] != 0 || doneq[1] != 1) begin
            n_fail++; $display("FAIL drop_done_order: %0d pulses, required src0 then src1", doneq.size());
        end
        d = first_diff();
        n_checks++;
        if (d != -1) begin n_fail++; $display("FAIL drop_bytes: first difference at %0d, required none", d); end
    endtask

    task automatic test_random();
        bit ok;
        int src, l, d;
        for (int k = 0; k < 6; k++) begin
            src = int'($urandom_range(0, 1));
            l = int'($urandom_range(0, 40));
            busy_cyc = int'($urandom_range(1, 12));
            for (int i = 0; i < l; i++) mem[src][i] = 8'($urandom);
            if (src == 0) len0_in = 9'(l); else len1_in = 9'(l);
            clear_mon();
            req_in = (src == 0) ? 2'b01 : 2'b10;
            wait_done(1, ok);
            req_in = 2'b00;
            repeat (15) @(posedge clk_in);
            #1;
            model_frame(src, l);
            d = first_diff();
            n_checks++;
            if (!ok || d != -1) begin n_fail++; $display("FAIL random_bytes[%0d]: first difference at %0d (src=%0d len=%0d)", k, d, src, l); end
            n_checks++;
            if (rdaddrq.size() != l) begin n_fail++; $display("FAIL random_reads[%0d]: %0d reads, required %0d", k, rdaddrq.size(), l); end
            n_checks++;
            if (doneq.size() != 1 || doneq[0] != src || busy_viol != 0) begin
                n_fail++; $display("FAIL random_done[%0d]: %0d pulses, busy errs=%0d, required one for src%0d", k, doneq.size(), busy_viol, src);
            end
        end
    endtask

    initial begin
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 512; i++) mem[s][i] = 8'h00;
        test_reset();
        test_basic();
        test_round_robin();
        test_zero_len();
        test_clamp();
        test_reset_mid();
        test_req_drop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
